// File: rtl/alu_uart_bridge.sv
// Sequential front-end between UART RX/TX and a combinational 8-bit ALU.
// Assembles A/B/opcode frames, holds them on the ALU, and forwards the result to TX.
module alu_uart_bridge #(
    parameter int DATA_W  = 8,
    parameter int OP_W    = 6,
    parameter int TIMEOUT = 1000000
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DATA_W-1:0] rx_data,
    input  logic              rx_done,
    output logic [DATA_W-1:0] alu_a,
    output logic [DATA_W-1:0] alu_b,
    output logic [OP_W-1:0]   alu_op,
    input  logic [DATA_W-1:0] alu_result,
    output logic [DATA_W-1:0] tx_data,
    output logic              tx_start,
    input  logic              tx_busy,
    input  logic              tx_done,
    output logic              overrun,
    output logic [2:0]        state_dbg
);

    localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = (TIMEOUT > 0) ? CNT_W'(TIMEOUT - 1) : '0;

    typedef enum logic [2:0] {
        WAIT_A  = 3'd0,
        WAIT_B  = 3'd1,
        WAIT_OP = 3'd2,
        CAPTURE = 3'd3,
        SEND    = 3'd4,
        WAIT_TX = 3'd5
    } state_t;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [DATA_W-1:0] alu_a_q, alu_a_d;
    logic [DATA_W-1:0] alu_b_q, alu_b_d;
    logic [OP_W-1:0]   alu_op_q, alu_op_d;
    logic [DATA_W-1:0] tx_data_q, tx_data_d;
    logic              tx_start_q, tx_start_d;
    logic              overrun_q, overrun_d;
    logic              timeout_s;
    logic              busy_state_s;

    // Next-state, datapath capture, timeout and overrun logic.
    always_comb begin
        state_d    = state_q;
        cnt_d      = '0;
        alu_a_d    = alu_a_q;
        alu_b_d    = alu_b_q;
        alu_op_d   = alu_op_q;
        tx_data_d  = tx_data_q;
        tx_start_d = 1'b0;

        timeout_s    = (TIMEOUT != 0) && (cnt_q == CNT_LAST);
        busy_state_s = (state_q == CAPTURE) || (state_q == SEND) || (state_q == WAIT_TX);
        // Bytes arriving while a result is in flight are dropped but remembered.
        overrun_d    = overrun_q | (rx_done & busy_state_s);

        case (state_q)
            WAIT_A: begin
                if (rx_done) begin
                    alu_a_d = rx_data;
                    state_d = WAIT_B;
                end else begin
                    state_d = WAIT_A;
                end
            end
            WAIT_B: begin
                if (rx_done) begin
                    alu_b_d = rx_data;
                    state_d = WAIT_OP;
                end else if (timeout_s) begin
                    state_d = WAIT_A;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            WAIT_OP: begin
                if (rx_done) begin
                    alu_op_d = rx_data[OP_W-1:0];
                    state_d  = CAPTURE;
                end else if (timeout_s) begin
                    state_d = WAIT_A;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            CAPTURE: begin
                // One cycle lets the ALU settle on the freshly registered operands.
                tx_data_d = alu_result;
                state_d   = SEND;
            end
            SEND: begin
                if (!tx_busy) begin
                    tx_start_d = 1'b1;
                    state_d    = WAIT_TX;
                end else begin
                    state_d = SEND;
                end
            end
            WAIT_TX: begin
                if (tx_done) begin
                    state_d = WAIT_A;
                end else begin
                    state_d = WAIT_TX;
                end
            end
            default: begin
                state_d = WAIT_A;
            end
        endcase
    end

    // State, counter and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= WAIT_A;
            cnt_q      <= '0;
            alu_a_q    <= '0;
            alu_b_q    <= '0;
            alu_op_q   <= '0;
            tx_data_q  <= '0;
            tx_start_q <= 1'b0;
            overrun_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            alu_a_q    <= alu_a_d;
            alu_b_q    <= alu_b_d;
            alu_op_q   <= alu_op_d;
            tx_data_q  <= tx_data_d;
            tx_start_q <= tx_start_d;
            overrun_q  <= overrun_d;
        end
    end

    assign alu_a     = alu_a_q;
    assign alu_b     = alu_b_q;
    assign alu_op    = alu_op_q;
    assign tx_data   = tx_data_q;
    assign tx_start  = tx_start_q;
    assign overrun   = overrun_q;
    assign state_dbg = state_q;

endmodule

// File: tb/tb_alu_uart_bridge.sv
// Randomized self-checking bench for alu_uart_bridge with a frame-level reference model.
module tb_alu_uart_bridge;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] rx_data = 8'h00;
    logic       rx_done = 1'b0;
    logic [7:0] alu_a, alu_b, alu_result, tx_data;
    logic [5:0] alu_op;
    logic       tx_start;
    logic       tx_busy = 1'b0;
    logic       tx_done = 1'b0;
    logic       overrun;
    logic [2:0] state_dbg;

    int n_checks = 0;
    int n_errors = 0;

    logic [7:0] exp_a = 8'h00, exp_b = 8'h00, exp_tx = 8'h00;
    logic [5:0] exp_op = 6'h00;
    logic       exp_ovr = 1'b0;

    localparam logic [5:0] OP_AND = 6'h24, OP_OR = 6'h25, OP_XOR = 6'h26, OP_NOR = 6'h27;
    localparam logic [5:0] OP_ADD = 6'h20, OP_SUB = 6'h22, OP_SRA = 6'h03, OP_SRL = 6'h02;
    logic [5:0] op_tab [8] = '{OP_AND, OP_OR, OP_XOR, OP_NOR, OP_ADD, OP_SUB, OP_SRA, OP_SRL};

    alu_uart_bridge #(.DATA_W(8), .OP_W(6), .TIMEOUT(20)) dut (
        .clk(clk), .rst_n(rst_n), .rx_data(rx_data), .rx_done(rx_done),
        .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_result(alu_result),
        .tx_data(tx_data), .tx_start(tx_start), .tx_busy(tx_busy), .tx_done(tx_done),
        .overrun(overrun), .state_dbg(state_dbg)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] ref_alu(input logic [7:0] a, input logic [7:0] b, input logic [5:0] op);
        case (op)
            OP_AND:  return a & b;
            OP_OR:   return a | b;
            OP_XOR:  return a ^ b;
            OP_NOR:  return ~(a | b);
            OP_ADD:  return a + b;
            OP_SUB:  return a - b;
            OP_SRA:  return 8'($signed(a) >>> b[2:0]);
            OP_SRL:  return a >> b[2:0];
            default: return 8'h00;
        endcase
    endfunction

    // Environment ALU driven from the bridge's registered operands.
    always_comb alu_result = ref_alu(alu_a, alu_b, alu_op);

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) @(negedge clk);
    endtask

    task automatic send_byte(input logic [7:0] b);
        rx_data = b;
        rx_done = 1'b1;
        @(negedge clk);
        rx_done = 1'b0;
        rx_data = 8'h00;
    endtask

    task automatic check_held(input string tag);
        check_eq({tag, "_a"}, 32'(alu_a), 32'(exp_a));
        check_eq({tag, "_b"}, 32'(alu_b), 32'(exp_b));
        check_eq({tag, "_op"}, 32'(alu_op), 32'(exp_op));
        check_eq({tag, "_tx"}, 32'(tx_data), 32'(exp_tx));
        check_eq({tag, "_ovr"}, 32'(overrun), 32'(exp_ovr));
    endtask

    // Full frame: bytes with gaps, optional TX busy stall, optional stray byte during WAIT_TX.
    task automatic run_frame(input logic [7:0] a, input logic [7:0] b, input logic [7:0] op,
                             input int busy, input int g1, input int g2, input bit inject);
        tx_busy = (busy > 0);
        send_byte(a);
        idle(g1);
        send_byte(b);
        idle(g2);
        send_byte(op);
        exp_a  = a;
        exp_b  = b;
        exp_op = op[5:0];
        check_eq("cap_state", 32'(state_dbg), 32'd3);
        check_eq("cap_a", 32'(alu_a), 32'(exp_a));
        check_eq("cap_b", 32'(alu_b), 32'(exp_b));
        check_eq("cap_op", 32'(alu_op), 32'(exp_op));
        @(negedge clk);
        exp_tx = ref_alu(a, b, op[5:0]);
        check_eq("send_state", 32'(state_dbg), 32'd4);
        check_eq("send_tx", 32'(tx_data), 32'(exp_tx));
        check_eq("send_nostart", 32'(tx_start), 32'd0);
        for (int i = 0; i < busy; i++) begin
            @(negedge clk);
            check_eq("busy_nostart", 32'(tx_start), 32'd0);
            check_eq("busy_tx", 32'(tx_data), 32'(exp_tx));
        end
        tx_busy = 1'b0;
        @(negedge clk);
        check_eq("start_pulse", 32'(tx_start), 32'd1);
        check_eq("wtx_state", 32'(state_dbg), 32'd5);
        tx_busy = 1'b1;
        @(negedge clk);
        check_eq("start_single", 32'(tx_start), 32'd0);
        if (inject) begin
            send_byte(8'h77);
            exp_ovr = 1'b1;
            check_eq("ovr_state", 32'(state_dbg), 32'd5);
            check_held("ovr");
        end
        idle(2);
        tx_busy = 1'b0;
        tx_done = 1'b1;
        @(negedge clk);
        tx_done = 1'b0;
        check_eq("done_state", 32'(state_dbg), 32'd0);
        check_held("done");
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        #2;
        check_eq("rst_state", 32'(state_dbg), 32'd0);
        check_held("rst");
        check_eq("rst_start", 32'(tx_start), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        run_frame(8'h0F, 8'hF0, 8'(OP_NOR), 0, 0, 0, 1'b0);
        check_eq("nor_result", 32'(tx_data), 32'h00);
        run_frame(8'hAA, 8'h55, 8'(OP_ADD), 10, 1, 2, 1'b0);
        check_eq("add_result", 32'(tx_data), 32'hFF);

        for (int k = 0; k < 20; k++) begin
            logic [7:0] ra, rb, rop;
            ra  = 8'($urandom);
            rb  = 8'($urandom);
            rop = {2'($urandom), op_tab[$urandom_range(0, 7)]};
            run_frame(ra, rb, rop, $urandom_range(0, 4), $urandom_range(0, 19),
                      $urandom_range(0, 19), 1'b0);
        end

        run_frame(8'h3C, 8'h0F, 8'(OP_XOR), 0, 0, 0, 1'b1);
        run_frame(8'h81, 8'h01, 8'(OP_SRA), 0, 0, 0, 1'b0);
        check_eq("ovr_sticky", 32'(overrun), 32'd1);

        // Timeout: lone A byte then silence.
        send_byte(8'h12);
        exp_a = 8'h12;
        idle(19);
        check_eq("to_before", 32'(state_dbg), 32'd1);
        @(negedge clk);
        check_eq("to_expired", 32'(state_dbg), 32'd0);
        check_held("to");
        idle(5);
        run_frame(8'h01, 8'h02, 8'(OP_SUB), 0, 0, 0, 1'b0);
        check_eq("to_fresh_a", 32'(alu_a), 32'h01);

        // Op byte arrives on the very cycle the timeout would expire.
        run_frame(8'h5A, 8'h0F, 8'hE5, 0, 19, 19, 1'b0);
        check_eq("trunc_op", 32'(alu_op), 32'h25);

        // Async reset while stalled in SEND.
        tx_busy = 1'b1;
        send_byte(8'h33);
        send_byte(8'h44);
        send_byte(8'(OP_OR));
        idle(3);
        check_eq("pre_rst_state", 32'(state_dbg), 32'd4);
        @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        exp_a = 8'h00; exp_b = 8'h00; exp_op = 6'h00; exp_tx = 8'h00; exp_ovr = 1'b0;
        check_eq("arst_state", 32'(state_dbg), 32'd0);
        check_eq("arst_start", 32'(tx_start), 32'd0);
        check_held("arst");
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            if (i == 3) tx_busy = 1'b0;
            @(negedge clk);
            check_eq("post_rst_start", 32'(tx_start), 32'd0);
            check_eq("post_rst_state", 32'(state_dbg), 32'd0);
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
